// File: rtl/control_pipe.sv
// control_pipe: decodes opcode/funct into the registered ID/EX control entry.
// It sits between the IF/ID latch and EX. It handles the valid/ready handshake,
// inserts a bubble on a load-use hazard, sequences multi-cycle MULT/DIV
// occupancy of EX, and honours flush and EX stalls.
module control_pipe #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter bit          LOADUSE_EN = 1'b1,
  parameter int unsigned REG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             out_valid,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             memread,
  output logic             memwrite,
  output logic             isbranch,
  output logic             regdst,
  output logic             alusrc,
  output logic             isjump,
  output logic [1:0]       aluop,
  output logic [REG_W-1:0] dst_reg,
  output logic             ismuldiv,
  output logic             illegal,
  output logic             busy
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  localparam int unsigned     CntW    = $clog2(MULDIV_LAT) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_LAT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StRun, StBusy} state_e;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memtoreg;
    logic             memread;
    logic             memwrite;
    logic             isbranch;
    logic             regdst;
    logic             alusrc;
    logic             isjump;
    logic [1:0]       aluop;
    logic [REG_W-1:0] dst_reg;
    logic             ismuldiv;
    logic             illegal;
  } idex_t;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  idex_t           idex_q;
  idex_t           dec;
  logic            rt_used;
  logic            hazard;
  logic            accept;

  // Decode the incoming instruction into a full ID/EX entry.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (opcode)
      OpRtype: begin
        dec.regwrite = 1'b1;
        dec.regdst   = 1'b1;
        dec.aluop    = 2'b00;
        dec.ismuldiv = funct inside {FnMult, FnMultu, FnDiv, FnDivu};
      end
      OpAddi: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b01;
      end
      OpLw: begin
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
        dec.memread  = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b01;
      end
      OpSw: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b01;
      end
      OpBeq, OpBne: begin
        dec.isbranch = 1'b1;
        dec.aluop    = 2'b10;
      end
      OpJ: begin
        dec.isjump = 1'b1;
        dec.aluop  = 2'b01;
      end
      OpAndi, OpOri, OpXori, OpSlti, OpLui: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b11;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Non-writing entries carry a zero destination so hazard logic ignores them.
    dec.dst_reg = dec.regwrite ? (dec.regdst ? rd : rt) : '0;
  end

  // Load-use hazard: the load in ID/EX targets a register the incoming instruction reads.
  always_comb begin
    rt_used = opcode inside {OpRtype, OpSw, OpBeq, OpBne};
    hazard  = LOADUSE_EN && idex_q.valid && idex_q.memread && (idex_q.dst_reg != '0) &&
              ((idex_q.dst_reg == rs) || ((idex_q.dst_reg == rt) && rt_used));
    in_ready = !reset && (state_q == StRun) && !hazard && !ex_stall && !flush;
    accept   = in_valid && in_ready;
  end

  // ID/EX register, MULDIV sequencer state and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      idex_q  <= '0;
    end else if (flush) begin
      state_q <= StRun;
      cnt_q   <= '0;
      idex_q  <= '0;
    end else if (!ex_stall) begin
      if (accept) begin
        idex_q <= dec;
        if (dec.ismuldiv && (MULDIV_LAT > 1)) begin
          state_q <= StBusy;
          cnt_q   <= CntLoad;
        end
      end else begin
        idex_q <= '0;
        if (state_q == StBusy) begin
          // Last occupied cycle: release EX so the next instruction issues next cycle.
          if (cnt_q > CntOne) begin
            cnt_q <= cnt_q - CntOne;
          end else begin
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
      end
    end
  end

  assign out_valid = idex_q.valid;
  assign regwrite  = idex_q.regwrite;
  assign memtoreg  = idex_q.memtoreg;
  assign memread   = idex_q.memread;
  assign memwrite  = idex_q.memwrite;
  assign isbranch  = idex_q.isbranch;
  assign regdst    = idex_q.regdst;
  assign alusrc    = idex_q.alusrc;
  assign isjump    = idex_q.isjump;
  assign aluop     = idex_q.aluop;
  assign dst_reg   = idex_q.dst_reg;
  assign ismuldiv  = idex_q.ismuldiv;
  assign illegal   = idex_q.illegal;
  assign busy      = (state_q == StBusy);

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: two instances share stimulus.
// Instance 0 uses MULDIV_LAT=4 with load-use detection on.
// Instance 1 uses MULDIV_LAT=1 with load-use detection off.
module tb_control_pipe;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, flush, ex_stall;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;

  logic [1:0] rdy, ov, rw, mtr, mr, mw, br, rdst, asrc, jmp, md, ill, bsy;
  logic [1:0] alu [2];
  logic [4:0] dst [2];

  always #5 clk = ~clk;

  control_pipe #(.MULDIV_LAT(4), .LOADUSE_EN(1'b1), .REG_W(5)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .flush(flush), .ex_stall(ex_stall),
    .out_valid(ov[0]), .regwrite(rw[0]), .memtoreg(mtr[0]), .memread(mr[0]),
    .memwrite(mw[0]), .isbranch(br[0]), .regdst(rdst[0]), .alusrc(asrc[0]), .isjump(jmp[0]),
    .aluop(alu[0]), .dst_reg(dst[0]), .ismuldiv(md[0]), .illegal(ill[0]), .busy(bsy[0])
  );

  control_pipe #(.MULDIV_LAT(1), .LOADUSE_EN(1'b0), .REG_W(5)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .flush(flush), .ex_stall(ex_stall),
    .out_valid(ov[1]), .regwrite(rw[1]), .memtoreg(mtr[1]), .memread(mr[1]),
    .memwrite(mw[1]), .isbranch(br[1]), .regdst(rdst[1]), .alusrc(asrc[1]), .isjump(jmp[1]),
    .aluop(alu[1]), .dst_reg(dst[1]), .ismuldiv(md[1]), .illegal(ill[1]), .busy(bsy[1])
  );

  typedef struct packed {
    logic v, rw, mtr, mr, mw, br, rdst, asrc, jmp;
    logic [1:0] aluop;
    logic [4:0] dst;
    logic md, ill;
  } ent_t;

  typedef struct packed {
    logic iv;
    logic [5:0] op, fn;
    logic [4:0] rsf, rtf, rdf;
    logic fl, stl;
  } stim_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat [2] = '{4, 1};
  bit   lu  [2] = '{1'b1, 1'b0};
  ent_t m_ent [2];
  ent_t m_nent [2];
  int   m_left [2];
  int   m_nleft [2];
  logic m_rdy [2];

  // Reference decode table: one row per instruction class.
  function automatic ent_t decode(logic [5:0] op, logic [5:0] fn, logic [4:0] t, logic [4:0] d);
    ent_t e;
    e = '0;
    e.v = 1'b1;
    case (op)
      6'h00: begin e.rw = 1; e.rdst = 1; e.aluop = 2'd0; e.md = (fn >= 6'h18 && fn <= 6'h1B); end
      6'h08: begin e.rw = 1; e.asrc = 1; e.aluop = 2'd1; end
      6'h23: begin e.rw = 1; e.mtr = 1; e.mr = 1; e.asrc = 1; e.aluop = 2'd1; end
      6'h2B: begin e.mw = 1; e.asrc = 1; e.aluop = 2'd1; end
      6'h04, 6'h05: begin e.br = 1; e.aluop = 2'd2; end
      6'h02: begin e.jmp = 1; e.aluop = 2'd1; end
      6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F: begin e.rw = 1; e.asrc = 1; e.aluop = 2'd3; end
      default: e.ill = 1;
    endcase
    if (e.rw) e.dst = e.rdst ? d : t;
    return e;
  endfunction

  function automatic stim_t mk(logic iv, logic [5:0] op, logic [5:0] fn, logic [4:0] a,
                               logic [4:0] b, logic [4:0] c, logic fl, logic stl);
    stim_t s;
    s.iv = iv; s.op = op; s.fn = fn; s.rsf = a; s.rtf = b; s.rdf = c; s.fl = fl; s.stl = stl;
    return s;
  endfunction

  function automatic logic [18:0] got(int k);
    return {ov[k], rw[k], mtr[k], mr[k], mw[k], br[k], rdst[k], asrc[k], jmp[k], alu[k],
            dst[k], md[k], ill[k], bsy[k]};
  endfunction

  function automatic logic [18:0] expv(int k);
    return {m_ent[k], m_left[k] != 0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ent[k] = '0;
      m_left[k] = 0;
    end
  endtask

  // Apply one cycle of inputs and predict readiness and the next entry.
  task automatic drive(input stim_t s);
    in_valid = s.iv; opcode = s.op; funct = s.fn; rs = s.rsf; rt = s.rtf; rd = s.rdf;
    flush = s.fl; ex_stall = s.stl;
    for (int k = 0; k < 2; k++) begin
      logic haz, uses_rt;
      uses_rt = s.op inside {6'h00, 6'h2B, 6'h04, 6'h05};
      haz = lu[k] && m_ent[k].v && m_ent[k].mr && (m_ent[k].dst != 5'd0) &&
            ((m_ent[k].dst == s.rsf) || ((m_ent[k].dst == s.rtf) && uses_rt));
      m_rdy[k] = !reset && (m_left[k] == 0) && !haz && !s.stl && !s.fl;
      if (s.fl) begin
        m_nent[k] = '0; m_nleft[k] = 0;
      end else if (s.stl) begin
        m_nent[k] = m_ent[k]; m_nleft[k] = m_left[k];
      end else if (s.iv && m_rdy[k]) begin
        m_nent[k] = decode(s.op, s.fn, s.rtf, s.rdf);
        m_nleft[k] = m_nent[k].md ? lat[k] - 1 : 0;
      end else begin
        m_nent[k] = '0;
        m_nleft[k] = (m_left[k] > 0) ? m_left[k] - 1 : 0;
      end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ent[k] = m_nent[k];
      m_left[k] = m_nleft[k];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(mk(1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got(k), rdy[k]} !== 20'b0) begin
        n_bad++;
        $display("FAIL reset dut%0d: outputs,ready got %h expected 0", k, {got(k), rdy[k]});
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_load_use();
    stim_t seq [4];
    seq[0] = mk(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    seq[1] = mk(1'b1, 6'h00, 6'h20, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
    seq[2] = seq[1];
    seq[3] = mk(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy[k] !== m_rdy[k]) begin
          n_bad++;
          $display("FAIL load_use ready dut%0d step %0d: got %b expected %b", k, i, rdy[k], m_rdy[k]);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (rdy !== 2'b10) begin
          n_bad++;
          $display("FAIL load_use bubble ready step 1: got %b expected 10", rdy);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL load_use outputs dut%0d step %0d: got %h expected %h", k, i, got(k), expv(k));
        end
      end
      if (i == 1 || i == 2) begin
        n_cmp++;
        if (ov !== ((i == 1) ? 2'b10 : 2'b11)) begin
          n_bad++;
          $display("FAIL load_use issue step %0d: out_valid got %b", i, ov);
        end
      end
    end
  endtask

  task automatic test_muldiv();
    stim_t seq [6];
    seq[0] = mk(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i < 6; i++) seq[i] = mk(1'b1, 6'h08, 6'h00, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({rdy[k], bsy[k]} !== {m_rdy[k], m_left[k] != 0}) begin
          n_bad++;
          $display("FAIL muldiv ready/busy dut%0d step %0d: got %b%b expected %b%b", k, i,
                   rdy[k], bsy[k], m_rdy[k], m_left[k] != 0);
        end
      end
      n_cmp++;
      if ({rdy[0], bsy[0], bsy[1]} !== ((i >= 1 && i <= 3) ? 3'b010 : 3'b100)) begin
        n_bad++;
        $display("FAIL muldiv sequence step %0d: ready0,busy0,busy1 got %b%b%b", i, rdy[0],
                 bsy[0], bsy[1]);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL muldiv outputs dut%0d step %0d: got %h expected %h", k, i, got(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_flush_illegal();
    stim_t seq [4];
    seq[0] = mk(1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    seq[1] = mk(1'b1, 6'h0D, 6'h00, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1);
    seq[2] = mk(1'b1, 6'h0D, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    seq[3] = mk(1'b1, 6'h3F, 6'h00, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy[k] !== m_rdy[k]) begin
          n_bad++;
          $display("FAIL flush ready dut%0d step %0d: got %b expected %b", k, i, rdy[k], m_rdy[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL flush outputs dut%0d step %0d: got %h expected %h", k, i, got(k), expv(k));
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (ov !== 2'b00) begin
          n_bad++;
          $display("FAIL flush squash: out_valid got %b expected 00", ov);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({ov[0], ill[0], rw[0], mw[0], mr[0]} !== 5'b11000) begin
          n_bad++;
          $display("FAIL illegal op: v,ill,rw,mw,mr got %b expected 11000",
                   {ov[0], ill[0], rw[0], mw[0], mr[0]});
        end
      end
    end
  endtask

  task automatic test_stall_reset();
    stim_t seq [6];
    seq[0] = mk(1'b1, 6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    seq[1] = mk(1'b1, 6'h08, 6'h00, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1);
    seq[2] = seq[1];
    seq[3] = mk(1'b1, 6'h08, 6'h00, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    seq[4] = mk(1'b1, 6'h00, 6'h1A, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    seq[5] = mk(1'b1, 6'h08, 6'h00, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy[k] !== m_rdy[k]) begin
          n_bad++;
          $display("FAIL stall ready dut%0d step %0d: got %b expected %b", k, i, rdy[k], m_rdy[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL stall outputs dut%0d step %0d: got %h expected %h", k, i, got(k), expv(k));
        end
      end
      if (i == 1 || i == 2) begin
        n_cmp++;
        if ({ov, mw} !== 4'b1111) begin
          n_bad++;
          $display("FAIL stall hold step %0d: out_valid,memwrite got %b expected 1111", i, {ov, mw});
        end
      end
    end
    // DIV is still occupying EX here; reset must clear everything without waiting for a clock.
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got(k), rdy[k]} !== 20'b0) begin
        n_bad++;
        $display("FAIL reset_busy dut%0d: outputs,ready got %h expected 0", k, {got(k), rdy[k]});
      end
    end
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h23, 6'h2B, 6'h04,
                             6'h05, 6'h02, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F, 6'h3F};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h18, 6'h19, 6'h1A, 6'h1B};
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s = mk(($urandom % 4) != 0, ops[$urandom % 16], fns[$urandom % 6],
             5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
             ($urandom % 12) == 0, ($urandom % 6) == 0);
      drive(s);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy[k] !== m_rdy[k]) begin
          n_bad++;
          $display("FAIL random ready dut%0d cycle %0d: got %b expected %b", k, i, rdy[k], m_rdy[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL random outputs dut%0d cycle %0d: got %h expected %h", k, i, got(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
    flush = 1'b0; ex_stall = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_muldiv();
    test_flush_illegal();
    test_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
